// File: rtl/mdu_ctrl_if.sv
// Pipeline-to-MDU bundle: E-stage operation/operands in, status and HI/LO read data out.
interface mdu_ctrl_if;
  logic [3:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        D_isMD;
  logic        start;
  logic        busy;
  logic        stall;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDUOut;

  modport master (
    output MDUOp, A, B, D_isMD,
    input  start, busy, stall, HI, LO, MDUOut
  );

  modport slave (
    input  MDUOp, A, B, D_isMD,
    output start, busy, stall, HI, LO, MDUOut
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide unit controller: computes the 64-bit result at issue,
// then holds busy for a fixed number of cycles before committing it to HI/LO.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic        clk,
  input logic        reset,
  mdu_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, MULT, DIV} state_e;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] temp_q, temp_d;

  logic        is_mul, is_div, start;
  logic [63:0] prod_s, prod_u, result;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quo_s, rem_s, divisor_u;

  assign is_mul = (bus.MDUOp == OP_MULT) || (bus.MDUOp == OP_MULTU);
  assign is_div = (bus.MDUOp == OP_DIV)  || (bus.MDUOp == OP_DIVU);
  assign start  = (state_q == IDLE) && (is_mul || is_div);

  assign prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
  assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};

  // Signed divide on magnitudes: sidesteps the 0x80000000 / -1 overflow and keeps
  // truncation toward zero. A zero divisor is replaced by 1 only to keep the divider defined.
  assign a_mag     = bus.A[31] ? 32'd0 - bus.A : bus.A;
  assign b_mag     = (bus.B == 32'd0) ? 32'd1 : (bus.B[31] ? 32'd0 - bus.B : bus.B);
  assign q_mag     = a_mag / b_mag;
  assign r_mag     = a_mag % b_mag;
  assign quo_s     = (bus.A[31] ^ bus.B[31]) ? 32'd0 - q_mag : q_mag;
  assign rem_s     = bus.A[31] ? 32'd0 - r_mag : r_mag;
  assign divisor_u = (bus.B == 32'd0) ? 32'd1 : bus.B;

  always_comb begin
    result = 64'd0;
    unique case (bus.MDUOp)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      // Divide by zero stages the current HI/LO, so completion rewrites them unchanged.
      OP_DIV:   result = (bus.B == 32'd0) ? {hi_q, lo_q} : {rem_s, quo_s};
      OP_DIVU:  result = (bus.B == 32'd0) ? {hi_q, lo_q}
                                          : {bus.A % divisor_u, bus.A / divisor_u};
      default:  result = 64'd0;
    endcase
  end

  // NOTE: every next-state signal takes its current value first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    temp_d  = temp_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = is_mul ? MULT : DIV;
          cnt_d   = is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
          temp_d  = result;
        end else if (bus.MDUOp == OP_MTHI) begin
          hi_d = bus.A;
        end else if (bus.MDUOp == OP_MTLO) begin
          lo_d = bus.A;
        end
      end
      MULT, DIV: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d    = temp_q[63:32];
          lo_d    = temp_q[31:0];
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      temp_q  <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      temp_q  <= temp_d;
    end
  end

  assign bus.start  = start;
  assign bus.busy   = (state_q != IDLE);
  assign bus.stall  = bus.D_isMD && (start || (state_q != IDLE));
  assign bus.HI     = hi_q;
  assign bus.LO     = lo_q;
  assign bus.MDUOut = (bus.MDUOp == OP_MFHI) ? hi_q :
                      (bus.MDUOp == OP_MFLO) ? lo_q : 32'd0;
endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, 5, busy cycles for mult/multu (range 1..15).
REQ-002 Parameter DIV_CYCLES, 10, busy cycles for div/divu (range 1..15).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 MDUOp  in  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 treated as none.
REQ-006 A  in  32  E-stage forwarded rs value.
REQ-007 B  in  32  E-stage forwarded rt value.
REQ-008 D_isMD  in  1  D-stage instruction is any of ops 1-8.
REQ-009 start  out  1  combinational; op 1-4 accepted this cycle.
REQ-010 busy  out  1  registered; operation in progress.
REQ-011 stall  out  1  combinational pipeline stall request to D stage.
REQ-012 HI  out  32  registered HI.
REQ-013 LO  out  32  registered LO.
REQ-014 MDUOut  out  32  combinational read data for mfhi/mflo.

Function
REQ-015 States: IDLE, MULT, DIV; busy SHALL be 1 exactly when state != IDLE.
REQ-016 start SHALL = (state==IDLE) & MDUOp in {1,2,3,4}.
REQ-017 On the edge ending a start cycle T: capture operands, compute 64-bit result into internal temp, load 4-bit counter with MULT_CYCLES or DIV_CYCLES, state -> MULT or DIV.
REQ-018 In MULT/DIV, counter SHALL decrement each edge; on the edge where counter==1: HI/LO <= temp, state -> IDLE.
REQ-019 Latency: busy high in cycles T+1..T+N (N = configured cycles); new HI/LO visible from cycle T+N+1.
REQ-020 mult: signed 32x32 -> 64, HI = product[63:32], LO = product[31:0]; multu: same, unsigned.
REQ-021 div: signed, quotient truncated toward zero into LO, remainder (sign of dividend) into HI; divu: unsigned.
REQ-022 Divide by zero (B==0, op 3/4): operation SHALL run full DIV_CYCLES with busy asserted, HI/LO SHALL remain unchanged at completion.
REQ-023 div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
REQ-024 mthi/mtlo in IDLE: HI or LO <= A on the same edge; no busy.
REQ-025 Any op 1-8 arriving while busy SHALL be ignored (no state, HI, LO change); upstream guarantees via stall.
REQ-026 MDUOut SHALL = HI for op 5, LO for op 6, else 0; reads current register values, never temp.
REQ-027 stall SHALL = D_isMD & (start | busy).
REQ-028 mthi/mtlo concurrent with completion edge cannot occur (REQ-025 blocks it); completion write wins by construction.

Reset
REQ-029 reset==0 SHALL immediately force state IDLE, counter 0, busy 0, HI 0, LO 0, temp 0, regardless of clk.
REQ-030 Reset mid-operation SHALL discard the pending result; after release, no HI/LO update occurs.
REQ-031 start, stall, MDUOut during reset SHALL follow their combinational definitions with state IDLE and HI=LO=0.

Verification
REQ-032 mult A=0xFFFFFFFF B=2 -> busy 5 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFE; multu same operands -> HI=0x00000001 LO=0xFFFFFFFE.
REQ-033 div A=0xFFFFFFF9(-7) B=2 -> busy 10 cycles, then LO=0xFFFFFFFD HI=0xFFFFFFFF; divu A=7 B=2 -> LO=3 HI=1.
REQ-034 mthi A=0x12345678, next cycle mflo after mtlo A=0xCAFEBABE -> HI=0x12345678, MDUOut=0xCAFEBABE, busy never 1.
REQ-035 divu B=0 after HI=5 LO=6 -> busy 10 cycles, HI=5 LO=6 afterwards.
REQ-036 mult issued, D_isMD=1 held -> stall=1 in start cycle and all 5 busy cycles, 0 in cycle T+6; mult arriving during busy leaves HI/LO unaffected.
REQ-037 div started, reset pulsed low at cycle T+4 -> busy 0, HI=LO=0 immediately, remain 0 through T+15.
